// File: rtl/cdr_multi_if.sv
// Strobe/phase inputs and chip decision, lock and correction outputs of cdr_multi.
interface cdr_multi_if #(
    parameter int unsigned N_CH = 2
);
    logic            i_flag;
    logic [N_CH-1:0] i_phase;
    logic [N_CH-1:0] o_data;
    logic            o_valid;
    logic            o_lock;
    logic [1:0]      o_adj;

    modport master (
        output i_flag, i_phase,
        input  o_data, o_valid, o_lock, o_adj
    );

    modport slave (
        input  i_flag, i_phase,
        output o_data, o_valid, o_lock, o_adj
    );
endinterface

// File: rtl/cdr_multi.sv
// Multi-channel chip-timing recovery: early/late loop on channel 0 steers the sample
// counter, all channels are decided at mid-chip, and lock is tracked from edge quality.
module cdr_multi #(
    parameter int unsigned OSR      = 5,
    parameter int unsigned N_CH     = 2,
    parameter int unsigned ACC_W    = 4,
    parameter int unsigned LOCK_CNT = 8,
    parameter int unsigned LOSS_CNT = 32
) (
    input  logic        i_clk,
    input  logic        i_rst,
    cdr_multi_if.slave  bus
);
    localparam int unsigned CntW  = $clog2(OSR);
    localparam int unsigned GoodW = $clog2(LOCK_CNT + 1);
    localparam int unsigned MissW = $clog2(LOSS_CNT + 1);
    localparam int          Th    = 2 ** (ACC_W - 2);
    localparam int unsigned Half  = (OSR - 1) / 2;
    localparam int unsigned Mid   = OSR / 2;
    localparam int unsigned Last  = OSR - 1;

    logic [CntW-1:0]         cnt_q, cnt_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [1:0]       pend_q, pend_d;
    logic                    prev_q, prev_d;
    logic                    prev_ok_q, prev_ok_d;
    logic [GoodW-1:0]        good_q, good_d;
    logic [MissW-1:0]        miss_q, miss_d;
    logic [N_CH-1:0]         data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    lock_q, lock_d;
    logic [1:0]              adj_q, adj_d;

    logic at_end, is_edge, late, early, is_good, decide;
    int   acc_n, pend_n;

    assign at_end  = (cnt_q == CntW'(Last));
    assign is_edge = prev_ok_q && (bus.i_phase[0] != prev_q);
    assign late    = is_edge && (cnt_q != '0) && (cnt_q <= CntW'(Half));
    assign early   = is_edge && (cnt_q > CntW'(Half));
    assign is_good = is_edge && (at_end || (cnt_q <= CntW'(1)));
    assign decide  = (cnt_q == CntW'(Mid));

    always_comb begin
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        pend_d    = pend_q;
        prev_d    = prev_q;
        prev_ok_d = prev_ok_q;
        good_d    = good_q;
        miss_d    = miss_q;
        data_d    = data_q;
        lock_d    = lock_q;
        valid_d   = 1'b0;
        adj_d     = 2'b00;
        acc_n     = 0;
        pend_n    = 0;
        if (bus.i_flag) begin
            prev_d    = bus.i_phase[0];
            prev_ok_d = 1'b1;
            acc_n     = int'(acc_q) + (late ? 1 : 0) - (early ? 1 : 0);
            pend_n    = at_end ? 0 : int'(pend_q);

            // Corrections only at chip end, so every chip still passes exactly one Mid.
            if (at_end) begin
                if (pend_q == 2'sd1) begin
                    cnt_d = cnt_q;
                    adj_d = 2'b10;
                end else if (pend_q == -2'sd1) begin
                    cnt_d = CntW'(1);
                    adj_d = 2'b01;
                end else begin
                    cnt_d = '0;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end

            if (acc_n == Th) begin
                acc_n = 0;
                if (pend_n < 1) pend_n = pend_n + 1;
            end else if (acc_n == -Th) begin
                acc_n = 0;
                if (pend_n > -1) pend_n = pend_n - 1;
            end
            acc_d  = ACC_W'(acc_n);
            pend_d = 2'(pend_n);

            // Decision is accounted before a coincident good edge clears miss.
            if (decide) begin
                data_d  = bus.i_phase;
                valid_d = 1'b1;
                if (miss_q != MissW'(LOSS_CNT)) miss_d = miss_q + 1'b1;
                if (miss_d == MissW'(LOSS_CNT)) begin
                    lock_d = 1'b0;
                    good_d = '0;
                end
            end

            if (is_good) begin
                miss_d = '0;
                if (good_d != GoodW'(LOCK_CNT)) good_d = good_d + 1'b1;
                if (good_d == GoodW'(LOCK_CNT)) lock_d = 1'b1;
            end else if (is_edge) begin
                good_d = '0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            pend_q    <= '0;
            prev_q    <= 1'b0;
            prev_ok_q <= 1'b0;
            good_q    <= '0;
            miss_q    <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            lock_q    <= 1'b0;
            adj_q     <= 2'b00;
        end else begin
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            pend_q    <= pend_d;
            prev_q    <= prev_d;
            prev_ok_q <= prev_ok_d;
            good_q    <= good_d;
            miss_q    <= miss_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            lock_q    <= lock_d;
            adj_q     <= adj_d;
        end
    end

    assign bus.o_data  = data_q;
    assign bus.o_valid = valid_q;
    assign bus.o_lock  = lock_q;
    assign bus.o_adj   = adj_q;
endmodule

// File: tb/tb_cdr_multi.sv
// Bench for cdr_multi: per-cycle comparison against a behavioural model, plus directed
// literal checks for reset, alignment, drift correction, loss of lock and mid-run reset.
module tb_cdr_multi;
    localparam int OSR      = 5;
    localparam int N_CH     = 2;
    localparam int ACC_W    = 4;
    localparam int LOCK_CNT = 8;
    localparam int LOSS_CNT = 32;
    localparam int TH       = 1 << (ACC_W - 2);

    logic i_clk = 1'b0;
    logic i_rst;
    always #5 i_clk = ~i_clk;

    cdr_multi_if #(.N_CH(N_CH)) bus ();

    cdr_multi #(
        .OSR(OSR), .N_CH(N_CH), .ACC_W(ACC_W), .LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT)
    ) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 0;

    // Model state: sample index, loop accumulator, pending correction, lock counters.
    int m_cnt, m_acc, m_pend, m_good, m_miss;
    bit m_prev, m_prev_ok;
    logic [N_CH-1:0] exp_data;
    logic            exp_valid, exp_lock;
    logic [1:0]      exp_adj;

    // Stimulus bookkeeping.
    int s_idx, n_edges, lock_at_edge, vse;
    bit tb_prev, tb_prev_ok;
    int valid_s[$];
    logic [N_CH-1:0] valid_dq[$];
    int adj_s[$];
    logic [1:0] adj_v[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    endtask

    task automatic model_step(input logic rst, input logic flag, input logic [N_CH-1:0] ph);
        int c;
        bit is_edge, good_e;
        exp_valid = 1'b0;
        exp_adj   = 2'b00;
        if (rst) begin
            m_cnt = 0; m_acc = 0; m_pend = 0; m_good = 0; m_miss = 0;
            m_prev = 0; m_prev_ok = 0;
            exp_data = '0; exp_lock = 1'b0;
            return;
        end
        if (!flag) return;
        c       = m_cnt;
        is_edge = m_prev_ok && (ph[0] != m_prev);
        good_e  = is_edge && (c == OSR - 1 || c <= 1);
        if (is_edge && c != 0) m_acc += (c <= (OSR - 1) / 2) ? 1 : -1;
        if (c == OSR - 1) begin
            if (m_pend > 0) begin m_cnt = OSR - 1; exp_adj = 2'b10; end
            else if (m_pend < 0) begin m_cnt = 1; exp_adj = 2'b01; end
            else m_cnt = 0;
            m_pend = 0;
        end else begin
            m_cnt = c + 1;
        end
        if (m_acc == TH) begin m_acc = 0; if (m_pend < 1) m_pend++; end
        else if (m_acc == -TH) begin m_acc = 0; if (m_pend > -1) m_pend--; end
        if (c == OSR / 2) begin
            exp_data = ph; exp_valid = 1'b1;
            if (m_miss < LOSS_CNT) m_miss++;
            if (m_miss == LOSS_CNT) begin exp_lock = 1'b0; m_good = 0; end
        end
        if (good_e) begin
            m_miss = 0;
            if (m_good < LOCK_CNT) m_good++;
            if (m_good == LOCK_CNT) exp_lock = 1'b1;
        end else if (is_edge) begin
            m_good = 0;
        end
        m_prev = ph[0]; m_prev_ok = 1;
    endtask

    always @(negedge i_clk) begin
        if (chk_en)
            check("outputs", {bus.o_data, bus.o_valid, bus.o_lock, bus.o_adj},
                  {exp_data, exp_valid, exp_lock, exp_adj});
    end

    task automatic cycle(input logic rst, input logic flag, input logic [N_CH-1:0] ph);
        i_rst = rst; bus.i_flag = flag; bus.i_phase = ph;
        @(posedge i_clk);
        #1;
        model_step(rst, flag, ph);
        chk_en = 1;
    endtask

    function automatic logic [N_CH-1:0] rand_ph();
        logic [N_CH-1:0] p;
        p = N_CH'($urandom);
        return p;
    endfunction

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, logic'(i % 2 == 0), rand_ph());
        s_idx = 0; n_edges = 0; lock_at_edge = -1; vse = 0;
        tb_prev = 0; tb_prev_ok = 0;
        valid_s.delete(); valid_dq.delete(); adj_s.delete(); adj_v.delete();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, rand_ph());
    endtask

    task automatic strobe(input logic [N_CH-1:0] ph);
        cycle(1'b0, 1'b1, ph);
        if (tb_prev_ok && ph[0] != tb_prev) begin n_edges++; vse = 0; end
        tb_prev = ph[0]; tb_prev_ok = 1;
        if (bus.o_valid) begin valid_s.push_back(s_idx); valid_dq.push_back(bus.o_data); vse++; end
        if (bus.o_adj != 2'b00) begin adj_s.push_back(s_idx); adj_v.push_back(bus.o_adj); end
        if (bus.o_lock && lock_at_edge < 0) lock_at_edge = n_edges;
        s_idx++;
    endtask

    // Transmitter with chip boundaries at strobe indices where (s + off) % OSR == 0.
    task automatic run_src(input int n, input int off, input int gap, input bit inv_ch1);
        logic [N_CH-1:0] ph;
        bit b;
        for (int i = 0; i < n; i++) begin
            b  = bit'(((s_idx + off) / OSR) % 2);
            ph = inv_ch1 ? {N_CH{~b}} : rand_ph();
            ph[0] = b;
            strobe(ph);
            idle(gap);
        end
    endtask

    initial begin
        logic [N_CH-1:0] ph;
        bit held, lost, on_valid, built;
        int loss_v;

        i_rst = 1'b1; bus.i_flag = 1'b0; bus.i_phase = '0;

        // Reset and aligned operation.
        do_reset(3);
        check("reset_outputs", {bus.o_data, bus.o_valid, bus.o_lock, bus.o_adj}, 0);
        run_src(4, 0, 4, 1);
        run_src(60, 0, 0, 1);
        check("first_valid_strobe", valid_s[0], 2);
        check("first_data", valid_dq[0], 2'b10);
        check("second_data", valid_dq[1], 2'b01);
        check("aligned_spacing", valid_s[5] - valid_s[4], OSR);
        check("aligned_lock_edge", lock_at_edge, LOCK_CNT);
        check("aligned_no_adj", adj_s.size(), 0);

        // Late drift: edges at c=1, retard after the 4th.
        do_reset(2);
        run_src(40, 4, 0, 0);
        check("late_adj_count", adj_s.size(), 1);
        check("late_adj_strobe", adj_s[0], 19);
        check("late_adj_value", adj_v[0], 2'b10);
        check("late_spacing", valid_s[4] - valid_s[3], OSR + 1);
        check("late_spacing_after", valid_s[5] - valid_s[4], OSR);

        // Early drift: edges at c=4, advance at the chip end after the 4th crossing.
        do_reset(2);
        run_src(40, 1, 1, 0);
        check("early_adj_count", adj_s.size(), 1);
        check("early_adj_strobe", adj_s[0], 24);
        check("early_adj_value", adj_v[0], 2'b01);
        check("early_spacing", valid_s[5] - valid_s[4], OSR - 1);

        // Loss of lock with ch0 frozen, then relock.
        do_reset(2);
        run_src(50, 0, 0, 1);
        check("loss_pre_lock", bus.o_lock, 1);
        held = tb_prev; lost = 0; loss_v = -1; on_valid = 0;
        for (int i = 0; i < 400 && !(lost && (s_idx % OSR) == 0); i++) begin
            ph = rand_ph(); ph[0] = held;
            strobe(ph);
            if (!lost && !bus.o_lock) begin lost = 1; loss_v = vse; on_valid = bus.o_valid; end
        end
        check("loss_seen", lost, 1);
        check("loss_decisions", loss_v, LOSS_CNT);
        check("loss_on_decision", on_valid, 1);
        n_edges = 0; lock_at_edge = -1;
        run_src(60, 0, 0, 1);
        check("relock_edge", lock_at_edge, LOCK_CNT);

        // Mid-run reset while locked with a pending correction.
        do_reset(2);
        run_src(50, 0, 0, 1);
        check("midrst_pre_lock", bus.o_lock, 1);
        built = 0;
        for (int i = 0; i < 60 && !built; i++) begin
            ph = rand_ph();
            ph[0] = (m_cnt == 1) ? ~tb_prev : tb_prev;
            strobe(ph);
            if (m_pend != 0) built = 1;
        end
        check("midrst_pend_setup", built, 1);
        check("midrst_lock_held", bus.o_lock, 1);
        cycle(1'b1, 1'b1, rand_ph());
        check("midrst_outputs", {bus.o_data, bus.o_valid, bus.o_lock, bus.o_adj}, 0);
        do_reset(2);
        run_src(30, 0, 0, 1);
        check("midrst_no_adj", adj_s.size(), 0);
        check("midrst_not_relocked", bus.o_lock, 0);

        // Randomized traffic: gaps, offset jumps, glitches and occasional resets.
        for (int r = 0; r < 6; r++) begin
            int off;
            bit b;
            do_reset($urandom_range(1, 3));
            off = $urandom_range(0, OSR - 1);
            for (int i = 0; i < 300; i++) begin
                if ($urandom_range(0, 39) == 0) off = $urandom_range(0, OSR - 1);
                b = bit'(((s_idx + off) / OSR) % 2);
                if ($urandom_range(0, 15) == 0) b = ~b;
                ph = rand_ph(); ph[0] = b;
                strobe(ph);
                idle($urandom_range(0, 2));
                if ($urandom_range(0, 199) == 0) do_reset(1);
            end
        end

        @(negedge i_clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/cdr_multi.md
# cdr_multi

Parametrised chip-timing recovery block, successor to the single-channel `cdr`. It counts `i_flag` sample strobes modulo an oversampling ratio and detects chip transitions on channel 0. A saturating early/late loop filter nudges the sample phase, and all `N_CH` hard-decision channels are sampled at mid-chip. It also reports lock status and applied corrections to the downstream despreader.

## Interface
- `OSR`, 5, samples (`i_flag` strobes) per chip; legal range 3..16.
- `N_CH`, 2, number of hard-decision phase channels sampled together; channel 0 drives timing.
- `ACC_W`, 4, loop accumulator width (signed); correction threshold `TH = 2^(ACC_W-2)`.
- `LOCK_CNT`, 8, number of good edges needed to assert lock.
- `LOSS_CNT`, 32, number of consecutive chips without a good edge that drops lock.
- `i_clk`  in  1  system clock; all logic is on the rising edge.
- `i_rst`  in  1  reset; synchronous and active-high.
- `i_flag`  in  1  sample strobe, one cycle per sample; may be high on consecutive cycles.
- `i_phase`  in  N_CH  hard phase decisions, valid when `i_flag`=1.
- `o_data`  out  N_CH  chip decision; held between updates.
- `o_valid`  out  1  one-cycle pulse when `o_data` is updated.
- `o_lock`  out  1  timing lock indicator.
- `o_adj`  out  2  one-cycle correction pulse: bit0 = advance applied, bit1 = retard applied.

## Operation
- Every action below happens only on cycles with `i_flag`=1. `c` denotes the pre-update value of `cnt`.
- `cnt` is the sample index, range 0..OSR-1. Normally it steps by +1 and wraps from OSR-1 to 0.
- Edge detection:
  - `prev` holds the last channel-0 sample.
  - An edge means `i_phase[0] != prev`.
  - Edge detection is disabled for the first strobe after reset (`prev_ok`=0).
- Edge classification by `c`:
  - `c`=0: on time.
  - 1 ≤ `c` ≤ (OSR-1)/2 (integer): late.
  - `c` > (OSR-1)/2: early.
  - Good edge: `c` ∈ {OSR-1, 0, 1}. Every other edge is bad.
- Loop filter:
  - A late edge adds +1 to `acc`; an early edge adds −1; an on-time edge or no edge leaves it unchanged.
  - If the new `acc` equals +TH: `acc`←0 and `pend`←`pend`+1.
  - If the new `acc` equals −TH: `acc`←0 and `pend`←`pend`−1.
  - `pend` ∈ {−1,0,+1} and saturates, so an opposite request cancels a pending one.
- Correction is applied only when `c`=OSR-1:
  - `pend`=+1 (retard): `cnt` stays at OSR-1; `o_adj[1]` pulses.
  - `pend`=−1 (advance): `cnt`←1, skipping 0; `o_adj[0]` pulses.
  - `pend`=0: normal wrap to 0.
  - `pend`←0 in the same cycle. This rule guarantees no decision is ever skipped or duplicated.
  - If a threshold crossing happens on the same strobe as `c`=OSR-1, the crossing goes into `pend` and is applied at the next chip end.
- Decision: when `c`=OSR/2 (integer), `o_data`←`i_phase` (all channels) and `o_valid` pulses.
- Lock tracking:
  - `good` counts good edges and saturates at LOCK_CNT; a bad edge clears `good`.
  - `o_lock`←1 when `good` reaches LOCK_CNT.
  - `miss` counts decisions since the last good edge, is cleared by a good edge, and saturates at LOSS_CNT.
  - When `miss` reaches LOSS_CNT: `o_lock`←0 and `good`←0.
  - A good edge and a decision on the same strobe: the decision is evaluated first, then the edge clears `miss`.
- Reset:
  - All state clears: `cnt`=0, `acc`=0, `pend`=0, `prev`=0, `prev_ok`=0, `good`=0, `miss`=0.
  - Outputs clear: `o_data`=0, `o_valid`=0, `o_lock`=0, `o_adj`=0.
  - Reset overrides `i_flag`. Reset mid-chip abandons any pending correction.

## Timing
- All outputs are registered. `o_data`/`o_valid` appear 1 clock after the strobe where `c`=OSR/2.
- `o_adj` pulses 1 clock after the chip-end strobe that applied the correction.
- `o_lock` changes 1 clock after the qualifying strobe.
- With no corrections, `o_valid` has a period of exactly OSR strobes. A retard gives OSR+1 strobes; an advance gives OSR−1.
- `o_valid` and `o_adj` are high for only one cycle, even when `i_flag` is high continuously.

## Test plan
- **Reset:** hold `i_rst`=1 for 3 cycles with `i_flag` toggling → all outputs 0. Release, then strobe every 5 clocks → the first `o_valid` arrives 1 clock after the 3rd strobe (`c`=2).
- **Aligned:** OSR=5; toggle ch0 at `c`=0 each chip; ch1=~ch0 → `o_valid` every 5 strobes, `o_data` alternates 2'b01/2'b10, `o_lock`=1 after the 8th edge, `o_adj` stays 0.
- **Late drift:** edges at `c`=1 → after the 4th edge `pend`=+1; at the next `c`=4 `cnt` holds and `o_adj`=2'b10. The following edges land at `c`=0 and the `o_valid` spacing that chip is 6 strobes.
- **Early drift:** edges at `c`=4 → `o_adj`=2'b01 after 4 edges, `cnt` jumps 4→1, the `o_valid` spacing is 4 strobes, and edges then land at `c`=0.
- **Loss:** while locked, hold ch0 constant → `o_lock` falls 1 clock after the 32nd decision. Resuming aligned toggles relocks after 8 good edges.
- **Mid-run reset:** assert `i_rst` while locked with `pend`≠0 → the next cycle shows all outputs 0, and no `o_adj` pulse appears after release.
